// File: rtl/my_ram8.sv
// my_ram8: 8-word x 16-bit register-file RAM with a hardware bulk-clear sweep.
// The single load strobe is decoded by address into per-word write enables.
// The addressed word is muxed combinationally onto out. A clear request starts
// a one-word-per-cycle zeroing sweep that the RAM64/RAM512 levels above use to
// wipe memory without CPU writes.
module my_ram8 #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     in,
  input  logic [ADDR_BITS-1:0] address,
  input  logic                 load,
  input  logic                 clear,
  output logic [WIDTH-1:0]     out,
  output logic                 busy
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_PTR = ADDR_BITS'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic                 busy_q, busy_d;

  logic [WIDTH-1:0]     mem_q [DEPTH];

  logic [DEPTH-1:0]     wr_en;
  logic [DEPTH-1:0]     sweep_en;
  logic                 idle;

  assign idle = (state_q == IDLE);

  // Decode load/address into one-hot write enables and ptr into sweep enables.
  // Writes are only taken in IDLE and lose to a simultaneous clear request,
  // so a write and a sweep can never target the same word in one cycle.
  always_comb begin
    wr_en    = '0;
    sweep_en = '0;
    for (int k = 0; k < DEPTH; k++) begin
      wr_en[k]    = load && !clear && idle && (address == ADDR_BITS'(k));
      sweep_en[k] = !idle && (ptr_q == ADDR_BITS'(k));
    end
  end

  // Sweep FSM next state: IDLE launches a sweep on clear, SWEEP walks ptr
  // across every word and returns to IDLE after zeroing the last one. The
  // pointer is reset to zero explicitly on exit rather than by wrap-around.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = SWEEP;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end
      end
      SWEEP: begin
        if (ptr_q == LAST_PTR) begin
          state_d = IDLE;
          ptr_d   = '0;
          busy_d  = 1'b0;
        end else begin
          ptr_d = ptr_q + ADDR_BITS'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sweep FSM registers; reset aborts any sweep in progress immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  // Storage: every word is reset, zeroed when the sweep reaches it, or
  // loaded from in when its decoded write enable is high; otherwise it holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (sweep_en[k]) begin
          mem_q[k] <= '0;
        end else if (wr_en[k]) begin
          mem_q[k] <= in;
        end
      end
    end
  end

  assign out  = mem_q[address];
  assign busy = busy_q;

endmodule

// File: tb/tb_my_ram8.sv
// tb_my_ram8: directed, scoreboard-driven bench for my_ram8.
// Expected {busy, out} pairs are queued as stimulus is applied and popped
// when the corresponding DUT output is sampled.
module tb_my_ram8;

  logic        clk;
  logic        reset_n;
  logic [15:0] in;
  logic [2:0]  address;
  logic        load;
  logic        clear;
  logic [15:0] out;
  logic        busy;

  int testsRun  = 0;
  int failCount = 0;

  logic [16:0] expQ [$];
  string       tagQ [$];

  logic [15:0] shadow [8];

  my_ram8 #(
    .WIDTH     (16),
    .ADDR_BITS (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (in),
    .address (address),
    .load    (load),
    .clear   (clear),
    .out     (out),
    .busy    (busy)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends, even if the stimulus stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive all DUT inputs in one go.
  task automatic applyStimulus(input logic [2:0] a, input logic [15:0] d,
                               input logic ld, input logic clr);
    address = a;
    in      = d;
    load    = ld;
    clear   = clr;
  endtask

  // Queue the {busy, out} value the DUT must show at the next check.
  task automatic pushExpect(input string tag, input logic b, input logic [15:0] v);
    expQ.push_back({b, v});
    tagQ.push_back(tag);
  endtask

  // Pop the oldest expectation and compare it with the live DUT outputs.
  task automatic checkOutput();
    logic [16:0] expVal;
    logic [16:0] obsVal;
    string       tag;
    testsRun++;
    if (expQ.size() == 0) begin
      failCount++;
      $error("[TB] FAIL scoreboard: observed empty queue, expected a pending entry");
    end else begin
      expVal = expQ.pop_front();
      tag    = tagQ.pop_front();
      obsVal = {busy, out};
      assert (obsVal === expVal) else begin
        failCount++;
        $error("[TB] FAIL %s: observed busy=%b out=%h, expected busy=%b out=%h",
               tag, obsVal[16], obsVal[15:0], expVal[16], expVal[15:0]);
      end
    end
  endtask

  // Advance past the next rising edge, leaving a small settle margin.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write one word while IDLE, checking the old value before the edge.
  task automatic writeWord(input logic [2:0] a, input logic [15:0] d);
    applyStimulus(a, d, 1'b1, 1'b0);
    pushExpect("pre-write", 1'b0, shadow[a]);
    #1 checkOutput();
    pushExpect("post-write", 1'b0, d);
    tick();
    checkOutput();
    shadow[a] = d;
    applyStimulus(a, 16'h0000, 1'b0, 1'b0);
  endtask

  // Directed sequence covering reset, read/write, isolation, sweep,
  // priority rules and asynchronous reset in the middle of a sweep.
  initial begin
    logic [15:0] val;
    for (int k = 0; k < 8; k++) shadow[k] = 16'h0000;
    reset_n = 1'b1;
    applyStimulus(3'd0, 16'h0000, 1'b0, 1'b0);
    #2 reset_n = 1'b0;

    // Reset values at every address, both during and after reset.
    for (int a = 0; a < 8; a++) begin
      applyStimulus(3'(a), 16'h0000, 1'b0, 1'b0);
      pushExpect("reset-read", 1'b0, 16'h0000);
      #1 checkOutput();
    end
    tick();
    tick();
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      applyStimulus(3'(a), 16'h0000, 1'b0, 1'b0);
      pushExpect("post-reset-read", 1'b0, 16'h0000);
      #1 checkOutput();
    end

    // Write 0x1111*k+1 into each word, then read them all back.
    for (int k = 0; k < 8; k++) begin
      val = 16'(16'h1111 * k + 1);
      writeWord(3'(k), val);
    end
    for (int k = 0; k < 8; k++) begin
      applyStimulus(3'(k), 16'hFFFF, 1'b0, 1'b0);
      pushExpect("readback", 1'b0, 16'(16'h1111 * k + 1));
      #1 checkOutput();
    end

    // Isolation between words, and load=0 must not write.
    writeWord(3'd5, 16'hBEEF);
    writeWord(3'd2, 16'h1234);
    applyStimulus(3'd5, 16'hFFFF, 1'b0, 1'b0);
    pushExpect("isolate-5", 1'b0, 16'hBEEF);
    tick();
    checkOutput();
    applyStimulus(3'd2, 16'hFFFF, 1'b0, 1'b0);
    pushExpect("isolate-2", 1'b0, 16'h1234);
    #1 checkOutput();
    applyStimulus(3'd6, 16'hFFFF, 1'b0, 1'b0);
    pushExpect("no-load-6", 1'b0, 16'(16'h1111 * 6 + 1));
    #1 checkOutput();

    // Bulk clear: address 7 holds 0xA5A5 until the 8th sweep edge.
    for (int k = 0; k < 8; k++) writeWord(3'(k), 16'hA5A5);
    applyStimulus(3'd7, 16'h0000, 1'b0, 1'b1);
    pushExpect("clear-edge", 1'b1, 16'hA5A5);
    tick();
    checkOutput();
    applyStimulus(3'd7, 16'h0000, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      pushExpect("sweep-a7", (i < 8), (i < 8) ? 16'hA5A5 : 16'h0000);
      tick();
      checkOutput();
    end
    for (int a = 0; a < 8; a++) begin
      applyStimulus(3'(a), 16'h0000, 1'b0, 1'b0);
      pushExpect("after-sweep", 1'b0, 16'h0000);
      #1 checkOutput();
      shadow[a] = 16'h0000;
    end

    // Clear beats a same-cycle load; loads and re-clears during the sweep
    // are ignored, and busy still drops 8 edges after the first clear.
    writeWord(3'd3, 16'h0303);
    applyStimulus(3'd3, 16'h7777, 1'b1, 1'b1);
    pushExpect("clear-beats-load", 1'b1, 16'h0303);
    tick();
    checkOutput();
    for (int i = 1; i <= 8; i++) begin
      if (i <= 3) applyStimulus(3'd0, 16'h5555, 1'b1, 1'b1);
      else        applyStimulus(3'd0, 16'h5555, 1'b1, 1'b0);
      if (i == 8) applyStimulus(3'd0, 16'h5555, 1'b0, 1'b0);
      pushExpect("busy-ignore", (i < 8), 16'h0000);
      tick();
      checkOutput();
    end
    applyStimulus(3'd3, 16'h0000, 1'b0, 1'b0);
    pushExpect("a3-swept", 1'b0, 16'h0000);
    #1 checkOutput();
    applyStimulus(3'd0, 16'h0000, 1'b0, 1'b0);
    pushExpect("a0-no-load", 1'b0, 16'h0000);
    tick();
    checkOutput();
    shadow[3] = 16'h0000;

    // Asynchronous reset during sweep cycle 4 wipes everything at once.
    for (int k = 0; k < 8; k++) writeWord(3'(k), 16'hA5A5);
    applyStimulus(3'd7, 16'h0000, 1'b0, 1'b1);
    pushExpect("clear-edge-2", 1'b1, 16'hA5A5);
    tick();
    checkOutput();
    applyStimulus(3'd7, 16'h0000, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      pushExpect("sweep-pre-reset", 1'b1, 16'hA5A5);
      tick();
      checkOutput();
    end
    #2 reset_n = 1'b0;
    pushExpect("async-reset", 1'b0, 16'h0000);
    #1 checkOutput();
    for (int a = 0; a < 8; a++) begin
      applyStimulus(3'(a), 16'h0000, 1'b0, 1'b0);
      pushExpect("reset-mid-sweep", 1'b0, 16'h0000);
      #1 checkOutput();
      shadow[a] = 16'h0000;
    end
    reset_n = 1'b1;
    writeWord(3'd4, 16'h4444);
    applyStimulus(3'd7, 16'h0000, 1'b0, 1'b0);
    pushExpect("a7-after-reset", 1'b0, 16'h0000);
    #1 checkOutput();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/my_ram8.md
Name: my_ram8

Overview:
- 8-word x 16-bit register-file RAM (nand2tetris RAM8).
- Sits directly downstream of the 1-to-8 load demultiplexer: the single `load` strobe is demuxed by `address` into per-word write enables.
- The stored word selected by `address` is muxed back to `out`.
- Adds a hardware bulk-clear sweep, used by the RAM64/RAM512 hierarchy above it to zero memory without CPU writes.

Parameters:
- WIDTH, 16, data word width in bits.
- ADDR_BITS, 3, address width; DEPTH = 2**ADDR_BITS words (8).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in  input  WIDTH  write data.
- address  input  ADDR_BITS  word select for both write and read.
- load  input  1  write strobe; demuxed by address to one word's enable.
- clear  input  1  request a bulk zero sweep of all words.
- out  output  WIDTH  contents of word[address].
- busy  output  1  high while a clear sweep is in progress.

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately, independent of clk):
  - all DEPTH words = 0.
  - FSM = IDLE, sweep pointer = 0, busy = 0.
  - out therefore = 0.
- Write enable decode:
  - word k enable = load & (address == k) & (state == IDLE) & ~clear.
  - Exactly one word, or none, is enabled per cycle.
- Write:
  - At the rising edge with its enable high, word[address] <= in.
  - Other words hold.
- Read:
  - out = word[address], combinational, no clock latency.
  - A write at edge t is visible on out after edge t (no write-through of `in` before the edge).
  - Changing address changes out in the same cycle.
- FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP at an edge where clear=1. That edge sets ptr <= 0 and busy <= 1. Any load in that cycle is dropped: clear has priority.
  - SWEEP: each edge performs word[ptr] <= 0, then ptr <= ptr+1.
  - When ptr == DEPTH-1, that edge zeroes the last word, sets state <= IDLE, busy <= 0, ptr <= 0.
  - busy is high for exactly DEPTH (8) cycles after the clear edge. Words are zeroed at clear edge +1 .. +8.
- During SWEEP:
  - load is ignored; no write occurs and no error is raised.
  - clear is ignored; the sweep does not restart.
  - out keeps tracking word[address], showing 0 for already-swept words and old data for pending ones.
- ptr width is ADDR_BITS. The wrap to 0 is explicit on exit, not relied upon by overflow.
- Reset mid-sweep aborts immediately: all words 0, IDLE, busy 0.
- Out-of-range address cannot occur (DEPTH = 2**ADDR_BITS); every address value maps to a word.
- No X on out after reset; all storage is reset.

Test Plan:
- Reset then read: hold reset_n=0, step address 0..7 -> out=0x0000 for every address, busy=0. Release reset -> values remain 0.
- Write/read each word: load=1, write in=0x1111*k+1 to address k for k=0..7, then load=0 and read back -> out matches each value. Before the write edge, out shows the old value.
- Isolation: write 0xBEEF at address 5, then write 0x1234 at address 2 -> address 5 still reads 0xBEEF, address 2 reads 0x1234. load=0 with in=0xFFFF changes nothing.
- Clear sweep: fill all words with 0xA5A5, pulse clear for 1 cycle, watch out at address 7:
  - busy=1 for exactly 8 cycles.
  - address 7 reads 0xA5A5 until the 8th sweep edge, then 0x0000.
  - After busy falls, all addresses read 0.
- Priority and ignore:
  - clear=1 and load=1 (address 3, in=0x7777) same cycle -> address 3 not written.
  - load of 0x5555 during busy -> dropped.
  - clear re-asserted during busy -> busy still falls 8 cycles after the first clear.
- Async reset mid-sweep: assert reset_n=0 between clock edges at sweep cycle 4 -> busy=0 and all out=0 immediately. Writes work normally on the first edge after release.
